// File: rtl/multi_net_capture_if.sv
// multi_net_capture_if: capture FIFO ports; out_timestamp exists only with MULTI_NET_CAPTURE_TIMESTAMP_EN
interface multi_net_capture_if #(
  parameter int CHANNELS = 2,
  parameter int LANES = 5,
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
);
  logic in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [$clog2(CHANNELS)-1:0] in_chan, out_chan;
  logic [LANES-1:0][WIDTH-1:0] in_data, out_data;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] chan_count [CHANNELS];
`ifdef MULTI_NET_CAPTURE_TIMESTAMP_EN
  logic [63:0] out_timestamp;
  modport master (output in_valid, in_chan, in_mode, in_data, out_ready,
                  input in_ready, out_valid, out_chan, out_data, level, chan_count, out_timestamp);
  modport slave (input in_valid, in_chan, in_mode, in_data, out_ready,
                 output in_ready, out_valid, out_chan, out_data, level, chan_count, out_timestamp);
`else
  modport master (output in_valid, in_chan, in_mode, in_data, out_ready,
                  input in_ready, out_valid, out_chan, out_data, level, chan_count);
  modport slave (input in_valid, in_chan, in_mode, in_data, out_ready,
                 output in_ready, out_valid, out_chan, out_data, level, chan_count);
`endif
endinterface

// File: rtl/multi_net_capture.sv
// multi_net_capture: tagged lane-reordering capture FIFO with per-channel counters; MULTI_NET_CAPTURE_TIMESTAMP_EN adds entry timestamps
module multi_net_capture #(
  parameter int CHANNELS = 2,
  parameter int LANES = 5,
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  multi_net_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef logic [LANES-1:0][WIDTH-1:0] data_t;
  data_t data_q [DEPTH];
  data_t data_d [DEPTH];
  logic [CW-1:0] chan_q [DEPTH];
  logic [CW-1:0] chan_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic [15:0] cnt_q [CHANNELS];
  logic [15:0] cnt_d [CHANNELS];
  logic push, pop;
  data_t in_x;
  assign bus.in_ready = level_q != FULL;
  assign bus.out_valid = level_q != '0;
  assign bus.out_data = bus.out_valid ? data_q[rd_q] : '0;
  assign bus.out_chan = bus.out_valid ? chan_q[rd_q] : '0;
  assign bus.level = level_q;
  assign bus.chan_count = cnt_q;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    for (int l = 0; l < LANES; l++) in_x[l] = bus.in_mode ? bus.in_data[l] : bus.in_data[LANES-1-l];
    data_d = data_q;
    chan_d = chan_q;
    if (push) begin
      data_d[wr_q] = in_x;
      chan_d[wr_q] = bus.in_chan;
    end
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    level_d = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
    // out-of-range tags match no counter, so they push without counting
    for (int c = 0; c < CHANNELS; c++)
      cnt_d[c] = (push && bus.in_chan == CW'(c) && cnt_q[c] != 16'hFFFF) ? cnt_q[c] + 16'd1 : cnt_q[c];
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    chan_q <= chan_d;
    if (rst) begin
      level_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      level_q <= level_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef MULTI_NET_CAPTURE_TIMESTAMP_EN
  logic [63:0] ts_q, ts_d;
  logic [63:0] stamp_q [DEPTH];
  logic [63:0] stamp_d [DEPTH];
  assign bus.out_timestamp = bus.out_valid ? stamp_q[rd_q] : '0;
  always_comb begin
    ts_d = ts_q + 64'd1;
    stamp_d = stamp_q;
    if (push) stamp_d[wr_q] = ts_q;
  end
  always_ff @(posedge clk) begin
    stamp_q <= stamp_d;
    ts_q <= rst ? '0 : ts_d;
  end
`endif
endmodule

// File: tb/tb_multi_net_capture.sv
// tb_multi_net_capture: directed checks of the capture FIFO, counters and reset
module tb_multi_net_capture;
  localparam int CHANNELS = 2, LANES = 5, WIDTH = 6, DEPTH = 8;
  typedef logic [LANES-1:0][WIDTH-1:0] data_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multi_net_capture_if #(.CHANNELS(CHANNELS), .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  multi_net_capture #(.CHANNELS(CHANNELS), .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  function automatic data_t mk(int b);
    data_t d;
    for (int l = 0; l < LANES; l++) d[l] = WIDTH'(b + l);
    return d;
  endfunction
  function automatic data_t rv(int b);
    data_t d;
    for (int l = 0; l < LANES; l++) d[l] = WIDTH'(b + LANES - 1 - l);
    return d;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_chan = '0;
    bus.in_mode = 1'b1;
    bus.in_data = '0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic push(int b, logic ch);
    bus.in_valid = 1'b1;
    bus.in_chan = ch;
    bus.in_data = mk(b);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.level !== 4'd0) begin fails++; $display("FAIL reset_level got %0d want 0", bus.level); end
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_flags got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid); end
    tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    for (int i = 0; i < 5; i++) push(i, 1'(i));
    tests++; if (bus.level !== 4'd5) begin fails++; $display("FAIL level5 got %0d want 5", bus.level); end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    tests++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset got lvl=%0d vld=%b rdy=%b want 0 0 1", bus.level, bus.out_valid, bus.in_ready); end
    tests++; if (bus.chan_count[0] !== 16'd0 || bus.chan_count[1] !== 16'd0) begin fails++; $display("FAIL reset_counts got %0d %0d want 0 0", bus.chan_count[0], bus.chan_count[1]); end
  endtask

  task automatic test_lanes();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_chan = 1'b0;
    bus.in_mode = 1'b1;
    bus.in_data = mk(1);
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL no_fallthrough got vld=%b want 0", bus.out_valid); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(1)) begin fails++; $display("FAIL keep_order got vld=%b data=%h want 1 %h", bus.out_valid, bus.out_data, mk(1)); end
    tests++; if (bus.level !== 4'd1 || bus.chan_count[0] !== 16'd1) begin fails++; $display("FAIL first_push got lvl=%0d cnt=%0d want 1 1", bus.level, bus.chan_count[0]); end
    bus.in_mode = 1'b0;
    push(1, 1'b1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests++; if (bus.out_data !== rv(1) || bus.out_chan !== 1'b1) begin fails++; $display("FAIL reverse got data=%h ch=%b want %h 1", bus.out_data, bus.out_chan, rv(1)); end
    tests++; if (bus.chan_count[1] !== 16'd1 || bus.chan_count[0] !== 16'd1) begin fails++; $display("FAIL chan_counts got %0d %0d want 1 1", bus.chan_count[0], bus.chan_count[1]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(7 * i, 1'b0);
      if (i == 7) begin
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
      end
    end
    tests++; if (bus.level !== 4'd8 || bus.chan_count[0] !== 16'd8) begin fails++; $display("FAIL full_level got lvl=%0d cnt=%0d want 8 8", bus.level, bus.chan_count[0]); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus.out_data !== mk(7 * i)) begin fails++; $display("FAIL drain%0d got %h want %h", i, bus.out_data, mk(7 * i)); end
      step();
    end
    bus.out_ready = 1'b0;
    tests++; if (bus.level !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin fails++; $display("FAIL drained got lvl=%0d vld=%b data=%h want 0 0 0", bus.level, bus.out_valid, bus.out_data); end
  endtask

  task automatic test_back_to_back();
    int ord [7] = '{30, 40, 1, 2, 3, 4, 5};
    do_reset();
    push(10, 1'b0);
    push(20, 1'b0);
    push(30, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = mk(40);
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.out_data !== mk(10)) begin fails++; $display("FAIL b2b_head got %h want %h", bus.out_data, mk(10)); end
    step();
    idle();
    tests++; if (bus.level !== 4'd3 || bus.out_data !== mk(20)) begin fails++; $display("FAIL b2b_level got lvl=%0d data=%h want 3 %h", bus.level, bus.out_data, mk(20)); end
    for (int i = 1; i <= 5; i++) push(i, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = mk(9);
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_pushpop_ready got %b want 0", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.level !== 4'd7) begin fails++; $display("FAIL full_pushpop_level got %0d want 7", bus.level); end
    for (int i = 0; i < 7; i++) begin
      tests++; if (bus.out_data !== mk(ord[i])) begin fails++; $display("FAIL order%0d got %h want %h", i, bus.out_data, mk(ord[i])); end
      step();
    end
    idle();
    tests++; if (bus.level !== 4'd0) begin fails++; $display("FAIL refused_entry got lvl=%0d want 0", bus.level); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.in_chan = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    tests++; if (bus.chan_count[1] !== 16'hFFFE || bus.chan_count[0] !== 16'd0) begin fails++; $display("FAIL count_fffe got %h %h want 0 fffe", bus.chan_count[0], bus.chan_count[1]); end
    step();
    tests++; if (bus.chan_count[1] !== 16'hFFFF) begin fails++; $display("FAIL count_ffff got %h want ffff", bus.chan_count[1]); end
    step();
    tests++; if (bus.chan_count[1] !== 16'hFFFF) begin fails++; $display("FAIL count_sat got %h want ffff", bus.chan_count[1]); end
    idle();
  endtask

`ifdef MULTI_NET_CAPTURE_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    tests++; if (bus.out_timestamp !== 64'd0) begin fails++; $display("FAIL ts_empty got %0d want 0", bus.out_timestamp); end
    repeat (10) step();
    push(1, 1'b0);
    repeat (2) step();
    push(2, 1'b0);
    tests++; if (bus.out_timestamp !== 64'd10) begin fails++; $display("FAIL ts_first got %0d want 10", bus.out_timestamp); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests++; if (bus.out_timestamp !== 64'd13) begin fails++; $display("FAIL ts_second got %0d want 13", bus.out_timestamp); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_lanes();
    test_full();
    test_back_to_back();
`ifdef MULTI_NET_CAPTURE_TIMESTAMP_EN
    test_timestamp();
`endif
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
